// File: rtl/an_scan_controller_if.sv
// Digit-scan controller bus: snapshot handshake from the requester, display drive to the mux/anodes.
interface an_scan_controller_if;
    logic       enable;
    logic       upd_req;
    logic [3:0] Ones_in;
    logic [3:0] Tens_in;
    logic [3:0] Hundreds_in;
    logic [3:0] Letters_in;
    logic       upd_ack;
    logic [3:0] Ones;
    logic [3:0] Tens;
    logic [3:0] Hundreds;
    logic [3:0] Letters;
    logic [1:0] AN_SEL;
    logic [3:0] AN;
    logic       frame_tick;

    // Requester / display consumer side
    modport master (
        output enable, upd_req, Ones_in, Tens_in, Hundreds_in, Letters_in,
        input  upd_ack, Ones, Tens, Hundreds, Letters, AN_SEL, AN, frame_tick
    );

    // Scan controller side
    modport slave (
        input  enable, upd_req, Ones_in, Tens_in, Hundreds_in, Letters_in,
        output upd_ack, Ones, Tens, Hundreds, Letters, AN_SEL, AN, frame_tick
    );
endinterface

// File: rtl/an_scan_controller.sv
// Seven-segment digit scanner: slot prescaler, digit select, frame-coherent
// digit snapshot with req/ack loading, and leading-zero blanked anode drive.
module an_scan_controller #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    an_scan_controller_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       hund_q, hund_d;
    logic [3:0]       lett_q, lett_d;
    logic             ack_q, ack_d;
    logic             ft_q, ft_d;
    logic [3:0]       an_q, an_d;

    logic             slot_tick_c;
    logic             wrap_c;
    logic             load_c;

    // Slot/frame timing and snapshot load decision
    always_comb begin
        slot_tick_c = bus.enable && (presc_q == CNT_MAX);
        wrap_c      = slot_tick_c && (sel_q == 2'd3);
        // While dark, a request presets the digits immediately; while scanning, only at a frame wrap
        load_c      = bus.upd_req && (bus.enable ? wrap_c : 1'b1);
    end

    // Next-state for prescaler, digit select, snapshot and pulses
    always_comb begin
        presc_d = presc_q;
        sel_d   = sel_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        hund_d  = hund_q;
        lett_d  = lett_q;
        ack_d   = load_c;
        ft_d    = wrap_c;

        if (!bus.enable) begin
            presc_d = '0;
        end else if (slot_tick_c) begin
            presc_d = '0;
            sel_d   = sel_q + 2'd1;
        end else begin
            presc_d = presc_q + CNT_W'(1);
        end

        if (load_c) begin
            ones_d = bus.Ones_in;
            tens_d = bus.Tens_in;
            hund_d = bus.Hundreds_in;
            lett_d = bus.Letters_in;
        end
    end

    // Anode drive from next-state select and snapshot so anode and mux switch together
    always_comb begin
        an_d = 4'b1111;
        if (bus.enable) begin
            an_d = ~(4'b0001 << sel_d);
            if (BLANK_LZ) begin
                if ((sel_d == 2'd2) && (hund_d == 4'd0)) begin
                    an_d = 4'b1111;
                end
                if ((sel_d == 2'd1) && (hund_d == 4'd0) && (tens_d == 4'd0)) begin
                    an_d = 4'b1111;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            sel_q   <= 2'd0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            hund_q  <= 4'd0;
            lett_q  <= 4'd0;
            ack_q   <= 1'b0;
            ft_q    <= 1'b0;
            an_q    <= 4'b1111;
        end else begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            hund_q  <= hund_d;
            lett_q  <= lett_d;
            ack_q   <= ack_d;
            ft_q    <= ft_d;
            an_q    <= an_d;
        end
    end

    assign bus.upd_ack    = ack_q;
    assign bus.Ones       = ones_q;
    assign bus.Tens       = tens_q;
    assign bus.Hundreds   = hund_q;
    assign bus.Letters    = lett_q;
    assign bus.AN_SEL     = sel_q;
    assign bus.AN         = an_q;
    assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_an_scan_controller.sv
// Randomized bench for an_scan_controller against a behavioural model, two DUTs (blanking on/off).
module tb_an_scan_controller;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       req = 1'b0;
    logic [3:0] d_o = 4'd0, d_t = 4'd0, d_h = 4'd0, d_l = 4'd0;

    int n_tests = 0;
    int n_fail  = 0;

    an_scan_controller_if ifa ();
    an_scan_controller_if ifb ();

    assign ifa.enable = en;      assign ifb.enable = en;
    assign ifa.upd_req = req;    assign ifb.upd_req = req;
    assign ifa.Ones_in = d_o;    assign ifb.Ones_in = d_o;
    assign ifa.Tens_in = d_t;    assign ifb.Tens_in = d_t;
    assign ifa.Hundreds_in = d_h; assign ifb.Hundreds_in = d_h;
    assign ifa.Letters_in = d_l; assign ifb.Letters_in = d_l;

    an_scan_controller #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    an_scan_controller #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         m_cnt;
    int         m_sel;
    logic [3:0] m_o, m_t, m_h, m_l;
    logic       m_ack, m_ft;
    logic [3:0] m_an [2];

    function automatic logic [3:0] exp_an(input int sel, input logic [3:0] h, input logic [3:0] t, input bit blank);
        logic [3:0] lit;
        lit = 4'b1111;
        lit[sel] = 1'b0;
        if (blank && sel == 2 && h == 0) lit = 4'b1111;
        if (blank && sel == 1 && h == 0 && t == 0) lit = 4'b1111;
        return lit;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_sel = 0;
            m_o = 0; m_t = 0; m_h = 0; m_l = 0;
            m_ack = 0; m_ft = 0;
            m_an[0] = 4'hF; m_an[1] = 4'hF;
        end else begin
            bit wrap;
            bit load;
            wrap = 0;
            if (en) begin
                if (m_cnt == DIV - 1) begin
                    m_cnt = 0;
                    wrap  = (m_sel == 3);
                    m_sel = (m_sel + 1) % 4;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_cnt = 0;
            end
            load = en ? (wrap && req) : req;
            if (load) begin
                m_o = d_o; m_t = d_t; m_h = d_h; m_l = d_l;
            end
            m_ack = load;
            m_ft  = wrap;
            m_an[0] = en ? exp_an(m_sel, m_h, m_t, 1'b1) : 4'hF;
            m_an[1] = en ? exp_an(m_sel, m_h, m_t, 1'b0) : 4'hF;
        end
    end

    task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    task automatic chk_dut(input int d, input logic [3:0] an, input logic [1:0] sel, input logic ack,
                           input logic ft, input logic [15:0] digs);
        chk("AN", d, 16'(an), 16'(m_an[d]));
        chk("AN_SEL", d, 16'(sel), 16'(m_sel));
        chk("upd_ack", d, 16'(ack), 16'(m_ack));
        chk("frame_tick", d, 16'(ft), 16'(m_ft));
        chk("digits", d, digs, {m_l, m_h, m_t, m_o});
    endtask

    // Continuous comparison on the inactive clock edge
    always @(negedge clk) begin
        chk_dut(0, ifa.AN, ifa.AN_SEL, ifa.upd_ack, ifa.frame_tick, {ifa.Letters, ifa.Hundreds, ifa.Tens, ifa.Ones});
        chk_dut(1, ifb.AN, ifb.AN_SEL, ifb.upd_ack, ifb.frame_tick, {ifb.Letters, ifb.Hundreds, ifb.Tens, ifb.Ones});
    end

    // ---------------- directed helpers ----------------
    task automatic check_reset_vals(input string nm);
        chk({nm, "_AN"}, 0, 16'(ifa.AN), 16'hF);
        chk({nm, "_SEL"}, 0, 16'(ifa.AN_SEL), 16'h0);
        chk({nm, "_ack"}, 0, 16'(ifa.upd_ack), 16'h0);
        chk({nm, "_ft"}, 0, 16'(ifa.frame_tick), 16'h0);
        chk({nm, "_dig"}, 0, {ifa.Letters, ifa.Hundreds, ifa.Tens, ifa.Ones}, 16'h0);
    endtask

    // Preload digits while dark, then enable scanning
    task automatic preload(input logic [3:0] o, input logic [3:0] t, input logic [3:0] h, input logic [3:0] l);
        @(negedge clk);
        en = 1'b0; req = 1'b1; d_o = o; d_t = t; d_h = h; d_l = l;
        @(posedge clk); #1;
        chk("preload_dig", 0, {ifa.Letters, ifa.Hundreds, ifa.Tens, ifa.Ones}, {l, h, t, o});
        chk("preload_ack", 0, 16'(ifa.upd_ack), 16'h1);
        chk("preload_dark", 0, 16'(ifa.AN), 16'hF);
        @(negedge clk);
        req = 1'b0;
        en  = 1'b1;
    endtask

    // One full frame with literal anode expectations per slot (nibble i = slot i)
    task automatic scan_check(input logic [15:0] ea, input logic [15:0] eb);
        int idx;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 1 || k == 4 || k == 8 || k == 12) begin
                idx = k / 4;
                chk("lit_AN", 0, 16'(ifa.AN), 16'(ea[idx*4 +: 4]));
                chk("lit_AN", 1, 16'(ifb.AN), 16'(eb[idx*4 +: 4]));
                chk("lit_SEL", 0, 16'(ifa.AN_SEL), 16'(idx));
            end
            if (k == 3) chk("lit_SEL_hold", 0, 16'(ifa.AN_SEL), 16'h0);
            if (k == 15) chk("lit_ft_pre", 0, 16'(ifa.frame_tick), 16'h0);
            if (k == 16) begin
                chk("lit_ft", 0, 16'(ifa.frame_tick), 16'h1);
                chk("lit_wrap_SEL", 0, 16'(ifa.AN_SEL), 16'h0);
            end
            if (k == 17) chk("lit_ft_post", 0, 16'(ifa.frame_tick), 16'h0);
        end
    endtask

    task automatic rand_digits();
        d_h = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
        d_t = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
        d_o = 4'($urandom_range(0, 9));
        d_l = 4'($urandom_range(0, 15));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset_vals("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Nominal scan O=5 T=3 H=2 L=A
        preload(4'd5, 4'd3, 4'd2, 4'hA);
        scan_check(16'h7BDE, 16'h7BDE);
        // H=0 T=0: Tens and Hundreds dark only with blanking
        preload(4'd7, 4'd0, 4'd0, 4'h1);
        scan_check(16'h7FFE, 16'h7BDE);
        // H=0 T=4: Tens lit, Hundreds dark
        preload(4'd7, 4'd4, 4'd0, 4'h2);
        scan_check(16'h7FDE, 16'h7BDE);

        // Randomized traffic: held handshake, enable toggles, async resets
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (req && ifa.upd_ack) begin
                req = 1'b0;
            end else if (!req && $urandom_range(0, 5) == 0) begin
                rand_digits();
                req = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) en = ~en;
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #1 check_reset_vals("async_rst");
                req = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
